s400_c3_phase_timer: RTL

- Sequential phase timer that owns the 4-bit C3 counter register in the s400 traffic-controller datapath.
- Advances C3 on prescaler ticks decoded from the upstream UC_8..UC_11 and UC_16..UC_19 counter bits.
- Sequences GREEN -> YELLOW -> RED, gating the exit from GREEN on a car request.
- Drives C3_Q0..C3_Q3, the current phase and a terminal-count pulse to the downstream C3 next-state/decode logic.

---
 rtl/s400_pkg.sv | 21 ++
 rtl/s400_step_gen.sv | 14 +
 rtl/s400_c3_phase_timer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/s400_pkg.sv
// Shared types and constants for the s400 C3 phase timer.
// Holds the phase encoding, default phase lengths and the C3 counter width.
package s400_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } phase_t;

    localparam int C3_W           = 4;
    localparam int GREEN_LEN_DEF  = 12;
    localparam int YELLOW_LEN_DEF = 4;
    localparam int RED_LEN_DEF    = 10;

    // A phase length must fit the counter: 1 .. 2**C3_W steps.
    function automatic bit len_ok(input int len);
        return (len >= 1) && (len <= (1 << C3_W));
    endfunction

endpackage

// File: rtl/s400_step_gen.sv
// Decodes the prescaler nibbles (or test mode) into the C3 step enable.
// Purely combinational, zero latency, no flow control.
module s400_step_gen
    import s400_pkg::*;
(
    input  logic       testl,
    input  logic [3:0] uc_lo,
    input  logic [3:0] uc_hi,
    output logic       step
);

    assign step = ~testl | ((&uc_lo) & (&uc_hi));

endmodule

// File: rtl/s400_c3_phase_timer.sv
// C3 phase timer: GREEN -> YELLOW -> RED sequencing on prescaler steps, CAR-gated GREEN exit.
// All outputs registered, one edge from step/CAR to new state; no backpressure.
module s400_c3_phase_timer
    import s400_pkg::*;
#(
    parameter int GREEN_LEN  = GREEN_LEN_DEF,
    parameter int YELLOW_LEN = YELLOW_LEN_DEF,
    parameter int RED_LEN    = RED_LEN_DEF
) (
    input  logic       CK,
    input  logic       RSTN,
    input  logic       CLR,
    input  logic       TESTL,
    input  logic       UC_8,
    input  logic       UC_9,
    input  logic       UC_10,
    input  logic       UC_11,
    input  logic       UC_16,
    input  logic       UC_17,
    input  logic       UC_18,
    input  logic       UC_19,
    input  logic       CAR,
    output logic       C3_Q0,
    output logic       C3_Q1,
    output logic       C3_Q2,
    output logic       C3_Q3,
    output logic [1:0] PHASE,
    output logic       TC
);

    if (!len_ok(GREEN_LEN) || !len_ok(YELLOW_LEN) || !len_ok(RED_LEN)) begin : g_bad_len
        $fatal(1, "s400_c3_phase_timer: phase lengths must be in 1..16");
    end

    // Last-count values are one bit wider than C3 so a length of 16 compares cleanly.
    localparam logic [C3_W:0]   G_LAST = (C3_W+1)'(GREEN_LEN - 1);
    localparam logic [C3_W:0]   Y_LAST = (C3_W+1)'(YELLOW_LEN - 1);
    localparam logic [C3_W:0]   R_LAST = (C3_W+1)'(RED_LEN - 1);
    localparam logic [C3_W-1:0] G_SAT  = C3_W'(GREEN_LEN - 1);

    phase_t          phase_q, phase_d;
    logic [C3_W-1:0] c3_q, c3_d;
    logic            tc_q, tc_d;
    logic            step;
    logic [C3_W:0]   len_last;
    logic            last;

    s400_step_gen u_step_gen (
        .testl (TESTL),
        .uc_lo ({UC_11, UC_10, UC_9, UC_8}),
        .uc_hi ({UC_19, UC_18, UC_17, UC_16}),
        .step  (step)
    );

    always_comb begin
        len_last = G_LAST;
        case (phase_q)
            YELLOW:  len_last = Y_LAST;
            RED:     len_last = R_LAST;
            default: len_last = G_LAST;
        endcase
    end

    // ">=" rather than "==" so an upset count past the end still exits the phase.
    assign last = ({1'b0, c3_q} >= len_last);

    always_comb begin
        phase_d = phase_q;
        c3_d    = c3_q;
        tc_d    = 1'b0;
        if (CLR) begin
            phase_d = GREEN;
            c3_d    = '0;
        end else if (phase_q != GREEN && phase_q != YELLOW && phase_q != RED) begin
            phase_d = GREEN;
            c3_d    = '0;
        end else if (step) begin
            if (!last) begin
                c3_d = c3_q + C3_W'(1);
            end else begin
                case (phase_q)
                    GREEN: begin
                        if (CAR) begin
                            phase_d = YELLOW;
                            c3_d    = '0;
                            tc_d    = 1'b1;
                        end else begin
                            c3_d = G_SAT;
                        end
                    end
                    YELLOW: begin
                        phase_d = RED;
                        c3_d    = '0;
                        tc_d    = 1'b1;
                    end
                    default: begin
                        phase_d = GREEN;
                        c3_d    = '0;
                        tc_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            phase_q <= GREEN;
            c3_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            c3_q    <= c3_d;
            tc_q    <= tc_d;
        end
    end

    assign {C3_Q3, C3_Q2, C3_Q1, C3_Q0} = c3_q;
    assign PHASE = phase_q;
    assign TC    = tc_q;

endmodule
